// File: rtl/sel_mult_pipe_if.sv
// Valid/ready bundle for the channel-select multiplier.
// The slave side is the pipeline; the master side feeds beats and drains products.
interface sel_mult_pipe_if #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 3
);
   localparam int SEL_W = $clog2(N_CH + 1);

   logic                     in_valid;
   logic                     in_ready;
   logic [SEL_W-1:0]         sel;
   logic [N_CH*DATA_W-1:0]   a_flat;
   logic [N_CH*DATA_W-1:0]   k_flat;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] product;
   logic                     sat_flag;
   logic                     sel_err;

   modport master (
      output in_valid, sel, a_flat, k_flat, out_ready,
      input  in_ready, out_valid, product, sat_flag, sel_err
   );

   modport slave (
      input  in_valid, sel, a_flat, k_flat, out_ready,
      output in_ready, out_valid, product, sat_flag, sel_err
   );
endinterface

// File: rtl/sel_mult_pipe.sv
// Two-stage channel-select multiplier: S1 picks an a/k pair, S2 holds the
// shifted and saturated (or wrapped) product. Full valid/ready backpressure.
module sel_mult_pipe #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 3,
   parameter int SHIFT  = 3,
   parameter bit SAT_EN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   sel_mult_pipe_if.slave bus
);
   localparam int SEL_W = $clog2(N_CH + 1);
   localparam int FW    = 2 * DATA_W;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] k;
      logic              zero;
      logic              err;
   } s1_t;

   typedef struct packed {
      logic [DATA_W-1:0] p;
      logic              sat;
      logic              err;
   } s2_t;

   s1_t s1_d;
   s1_t s1_q;
   logic s1_valid;
   s2_t s2_d;
   s2_t s2_q;
   logic s2_valid;

   logic s2_adv;
   logic s1_free;
   logic accept;
   logic sel_hit;

   logic signed [FW-1:0] full;
   logic signed [FW-1:0] sh;
   logic [FW-DATA_W:0]   hi;
   logic                 ovf;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_free      = !s1_valid || s2_adv;
   assign bus.in_ready = s1_free && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   // Channel select; an unmatched nonzero sel is an out-of-range beat.
   always_comb begin
      s1_d    = '0;
      sel_hit = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.sel == SEL_W'(i + 1)) begin
            s1_d.a  = bus.a_flat[i*DATA_W +: DATA_W];
            s1_d.k  = bus.k_flat[i*DATA_W +: DATA_W];
            sel_hit = 1'b1;
         end
      end
      s1_d.zero = (bus.sel == '0);
      s1_d.err  = !sel_hit && (bus.sel != '0);
   end

   // Overflow when the bits above the result sign are not all sign copies.
   always_comb begin
      full = $signed(s1_q.a) * $signed(s1_q.k);
      sh   = full >>> SHIFT;
      hi   = sh[FW-1:DATA_W-1];
      ovf  = (|hi) && !(&hi);
      s2_d = '0;
      if (s1_q.zero || s1_q.err) begin
         s2_d.err = s1_q.err;
      end else if (SAT_EN && ovf) begin
         s2_d.p   = sh[FW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
         s2_d.sat = 1'b1;
      end else begin
         s2_d.p = sh[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s2_valid <= 1'b0;
         s2_q     <= '0;
      end else begin
         if (s1_free) begin
            s1_valid <= accept;
            if (accept)
               s1_q <= s1_d;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid)
               s2_q <= s2_d;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.product   = s2_q.p;
   assign bus.sat_flag  = s2_q.sat;
   assign bus.sel_err   = s2_q.err;
endmodule

// File: tb/tb_sel_mult_pipe.sv
// Directed bench for sel_mult_pipe: three instances share one stimulus
// (3ch saturating, 5ch saturating, 3ch wrapping).
module tb_sel_mult_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  sel3 = '0;
   logic [39:0] a40 = '0;
   logic [39:0] k40 = '0;

   int n_checks = 0;
   int n_fail = 0;

   logic signed [7:0] pa, pb, pc;
   logic sa, sb, sc, ea, eb, ec;
   int lat;

   always #5 clk = ~clk;

   sel_mult_pipe_if #(.DATA_W(8), .N_CH(3)) ia ();
   sel_mult_pipe_if #(.DATA_W(8), .N_CH(5)) ib ();
   sel_mult_pipe_if #(.DATA_W(8), .N_CH(3)) ic ();

   assign ia.in_valid  = in_valid;
   assign ia.sel       = sel3[1:0];
   assign ia.a_flat    = a40[23:0];
   assign ia.k_flat    = k40[23:0];
   assign ia.out_ready = out_ready;
   assign ib.in_valid  = in_valid;
   assign ib.sel       = sel3;
   assign ib.a_flat    = a40;
   assign ib.k_flat    = k40;
   assign ib.out_ready = out_ready;
   assign ic.in_valid  = in_valid;
   assign ic.sel       = sel3[1:0];
   assign ic.a_flat    = a40[23:0];
   assign ic.k_flat    = k40[23:0];
   assign ic.out_ready = out_ready;

   sel_mult_pipe #(.DATA_W(8), .N_CH(3), .SHIFT(3), .SAT_EN(1'b1))
      u_a (.clk(clk), .rst(rst), .bus(ia));
   sel_mult_pipe #(.DATA_W(8), .N_CH(5), .SHIFT(3), .SAT_EN(1'b1))
      u_b (.clk(clk), .rst(rst), .bus(ib));
   sel_mult_pipe #(.DATA_W(8), .N_CH(3), .SHIFT(3), .SAT_EN(1'b0))
      u_c (.clk(clk), .rst(rst), .bus(ic));

   function automatic logic [39:0] pack(input int ch, input logic [7:0] v);
      logic [39:0] r;
      r = '0;
      r[ch*8 +: 8] = v;
      return r;
   endfunction

   task automatic run_beat(input logic [2:0] s, input logic [39:0] a,
                           input logic [39:0] k);
      @(negedge clk);
      in_valid = 1'b1;
      sel3 = s;
      a40 = a;
      k40 = k;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 99;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (ia.out_valid) begin
            lat = i;
            break;
         end
      end
      pa = ia.product; sa = ia.sat_flag; ea = ia.sel_err;
      pb = ib.product; sb = ib.sat_flag; eb = ib.sel_err;
      pc = ic.product; sc = ic.sat_flag; ec = ic.sel_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (ia.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid got %b want 0", ia.out_valid);
      end
      n_checks++;
      if (ia.product !== 8'sd0 || ia.sat_flag !== 1'b0 || ia.sel_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got p=%0d s=%b e=%b want 0/0/0",
                  ia.product, ia.sat_flag, ia.sel_err);
      end
      n_checks++;
      if (ia.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready got %b want 0", ia.in_ready);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (ia.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_in_ready got %b want 1", ia.in_ready);
      end
   endtask

   task automatic test_basic();
      run_beat(3'd1, pack(0, 8'sd20), pack(0, 8'sd10));
      n_checks++;
      if (lat != 2) begin
         n_fail++; $display("FAIL basic_latency got %0d want 2", lat);
      end
      n_checks++;
      if (pa !== 8'sd25 || sa !== 1'b0 || ea !== 1'b0) begin
         n_fail++; $display("FAIL basic_product got %0d s=%b e=%b want 25 0 0", pa, sa, ea);
      end
   endtask

   task automatic test_signed();
      run_beat(3'd2, pack(1, -8'sd7), pack(1, 8'sd3));
      n_checks++;
      if (pa !== -8'sd3) begin
         n_fail++; $display("FAIL floor_shift got %0d want -3", pa);
      end
      run_beat(3'd3, pack(2, -8'sd20), pack(2, 8'sd10));
      n_checks++;
      if (pa !== -8'sd25 || pb !== -8'sd25) begin
         n_fail++; $display("FAIL sel3_product got %0d/%0d want -25/-25", pa, pb);
      end
   endtask

   task automatic test_saturate();
      run_beat(3'd1, pack(0, 8'sd127), pack(0, 8'sd127));
      n_checks++;
      if (pa !== 8'sd127 || sa !== 1'b1) begin
         n_fail++; $display("FAIL sat_pos got %0d s=%b want 127 1", pa, sa);
      end
      n_checks++;
      if (pc !== -8'sd32 || sc !== 1'b0) begin
         n_fail++; $display("FAIL wrap_pos got %0d s=%b want -32 0", pc, sc);
      end
      run_beat(3'd1, pack(0, 8'h80), pack(0, 8'sd127));
      n_checks++;
      if (pa !== -8'sd128 || sa !== 1'b1) begin
         n_fail++; $display("FAIL sat_neg got %0d s=%b want -128 1", pa, sa);
      end
      n_checks++;
      if (pc !== 8'sd16 || sc !== 1'b0) begin
         n_fail++; $display("FAIL wrap_neg got %0d s=%b want 16 0", pc, sc);
      end
      run_beat(3'd1, pack(0, 8'sd127), pack(0, 8'sd8));
      n_checks++;
      if (pa !== 8'sd127 || sa !== 1'b0) begin
         n_fail++; $display("FAIL edge_pos got %0d s=%b want 127 0", pa, sa);
      end
      run_beat(3'd1, pack(0, 8'h80), pack(0, 8'sd8));
      n_checks++;
      if (pa !== -8'sd128 || sa !== 1'b0) begin
         n_fail++; $display("FAIL edge_neg got %0d s=%b want -128 0", pa, sa);
      end
   endtask

   task automatic test_sel_range();
      run_beat(3'd5, pack(4, 8'sd16), pack(4, -8'sd16));
      n_checks++;
      if (pb !== -8'sd32 || eb !== 1'b0) begin
         n_fail++; $display("FAIL last_channel got %0d e=%b want -32 0", pb, eb);
      end
      run_beat(3'd6, {5{8'sd20}}, {5{8'sd10}});
      n_checks++;
      if (lat != 2 || pb !== 8'sd0 || eb !== 1'b1 || sb !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_err_beat got lat=%0d p=%0d e=%b s=%b want 2 0 1 0",
                  lat, pb, eb, sb);
      end
      run_beat(3'd0, {5{8'sd20}}, {5{8'sd10}});
      n_checks++;
      if (lat != 2 || pb !== 8'sd0 || eb !== 1'b0 || pa !== 8'sd0) begin
         n_fail++;
         $display("FAIL zero_sel got lat=%0d p=%0d/%0d e=%b want 2 0/0 0",
                  lat, pb, pa, eb);
      end
      @(negedge clk);
      n_checks++;
      if (ib.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL zero_sel_pulse got out_valid %b want 0", ib.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]        bs[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
      logic [7:0]        ba[4] = '{8'd20, 8'hF9, 8'd8, 8'd50};
      logic [7:0]        bk[4] = '{8'd10, 8'd3, 8'd10, 8'd50};
      logic signed [7:0] exp_v[4] = '{8'sd25, -8'sd3, 8'sd10, 8'sd0};
      logic signed [7:0] got[$];
      logic signed [7:0] hold_p;
      logic held;
      int idx;
      idx = 0;
      held = 1'b0;
      hold_p = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         out_ready = !(c >= 2 && c <= 6);
         if (idx < 4) begin
            in_valid = 1'b1;
            sel3 = bs[idx];
            a40 = (bs[idx] == 3'd0) ? {5{ba[idx]}} : pack(int'(bs[idx]) - 1, ba[idx]);
            k40 = (bs[idx] == 3'd0) ? {5{bk[idx]}} : pack(int'(bs[idx]) - 1, bk[idx]);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c == 2) begin
            n_checks++;
            if (ia.in_ready !== 1'b0) begin
               n_fail++; $display("FAIL stall_in_ready got %b want 0", ia.in_ready);
            end
         end
         if (ia.out_valid && !out_ready) begin
            if (held) begin
               n_checks++;
               if (ia.product !== hold_p) begin
                  n_fail++;
                  $display("FAIL stall_hold cycle %0d got %0d want %0d", c, ia.product, hold_p);
               end
            end
            hold_p = ia.product;
            held = 1'b1;
         end else begin
            held = 1'b0;
         end
         if (ia.out_valid && out_ready) got.push_back(ia.product);
         if (in_valid && ia.in_ready) idx++;
         if (got.size() == 4) break;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL stream_count got %0d want 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp_v[i]) begin
            n_fail++; $display("FAIL stream_order beat %0d got %0d want %0d", i, got[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      in_valid = 1'b1; sel3 = 3'd1;
      a40 = pack(0, 8'sd20); k40 = pack(0, 8'sd10);
      @(negedge clk);
      sel3 = 3'd2;
      a40 = pack(1, -8'sd7); k40 = pack(1, 8'sd3);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (ia.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_in_ready got %b want 0", ia.in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (ia.out_valid !== 1'b0 || ia.product !== 8'sd0) begin
         n_fail++;
         $display("FAIL mid_rst_flush got v=%b p=%0d want 0 0", ia.out_valid, ia.product);
      end
      rst = 1'b0;
      run_beat(3'd3, pack(2, -8'sd20), pack(2, 8'sd10));
      n_checks++;
      if (lat != 2 || pa !== -8'sd25) begin
         n_fail++; $display("FAIL post_rst_beat got lat=%0d p=%0d want 2 -25", lat, pa);
      end
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (ia.out_valid) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL post_rst_stale got %0d extra pulses want 0", pulses);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_saturate();
      test_sel_range();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
